vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA control unit. Generates HS, VS, the bright (active video) flag and pixel coordinates for any VGA mode, with programmable sync polarity and a run/stall enable. Adds a lookahead pixel-request port that leads the display position by LOOKAHEAD cycles, so a frame buffer or camera line buffer with read latency can deliver pixels aligned with bright. Sits between the clock divider (clk_25 domain) and the frame buffer / image generator.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width (cycles)
H_BP, 48, horizontal back porch (cycles, >=1)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines, >=1)
HS_POL, 0, active level of hs (0 = active-low)
VS_POL, 0, active level of vs
LOOKAHEAD, 2, request lead in cycles, 0..H_TOTAL-1
CW, 11, width of all counters/coordinates

Ports:
clk_25 input 1 pixel clock
reset input 1 synchronous, active-high reset
enable input 1 advance timing when 1; freeze when 0
hs output 1 horizontal sync, polarity HS_POL
vs output 1 vertical sync, polarity VS_POL
bright output 1 current position is visible
h_count output CW current horizontal position
v_count output CW current line
line_start output 1 one-cycle pulse, h_count==0
frame_start output 1 one-cycle pulse, (h_count,v_count)==(0,0)
req_valid output 1 lookahead position is visible
req_x output CW lookahead x (valid when req_valid)
req_y output CW lookahead y (valid when req_valid)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Only clock is clk_25; reset is synchronous and active-high.
- Per line, h region order: active [0,H_ACTIVE), FP, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), BP. Vertical regions follow the same order, counted in lines.
- All outputs are registered and mutually aligned: hs/vs/bright/line_start/frame_start decode the h_count/v_count shown on the same cycle.
- Reset state: h_count=H_TOTAL-1, v_count=V_TOTAL-1 (last cycle of the frame); hs=~HS_POL, vs=~VS_POL, bright=0, line_start=0, frame_start=0, req_valid=0, req_x=0, req_y=0.
- First enabled edge after reset: (0,0), bright=1, line_start=1, frame_start=1.
- Enabled edge: h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps V_TOTAL-1 -> 0. Counter widths never overflow CW (static requirement: H_TOTAL, V_TOTAL <= 2^CW).
- bright = (h_count<H_ACTIVE) && (v_count<V_ACTIVE). hs is active during the h sync region on every line, including vertical blanking. vs is active for all cycles of the V_SYNC lines; it changes on the h_count==0 cycle.
- Lookahead: a second counter pair tracks the position LOOKAHEAD cycles ahead, wrapping across line and frame boundaries exactly as the main counters do. req_valid/req_x/req_y describe that position; req_x=h_count+LOOKAHEAD modulo the line, with carry into req_y. A consumer with latency LOOKAHEAD presents data aligned with bright for the same pixel.
- LOOKAHEAD=0: req_* equal bright/h_count/v_count every cycle.
- First frame after reset: positions 0..LOOKAHEAD-1 of line 0 are never requested (req_valid stays 0 until the first enabled edge). Consumers must tolerate this; every subsequent frame is requested in full.
- enable=0: all counters and hs/vs hold. bright, req_valid, line_start and frame_start are forced to 0 while enable=0. On re-enable, timing resumes from the held position with no skipped or repeated position.
- reset asserted mid-frame: the reset state is applied on the next clk_25 edge, overriding enable.

Test Plan:
- Small mode (H 8/2/3/2 -> H_TOTAL=15; V 4/1/2/1 -> V_TOTAL=8; LOOKAHEAD=0). Release reset with enable=1 -> first edge gives h=0, v=0, bright=1, line_start=1, frame_start=1. frame_start repeats every 120 cycles.
- Same mode, check hsync -> hs low exactly for h_count 10..12 on every one of lines 0..7. bright is high only for h<8, v<4, i.e. 32 cycles per frame.
- vsync, default polarity -> vs low for v_count 5..6 (30 cycles). Rerun with VS_POL=1, HS_POL=1 -> the same windows are high.
- LOOKAHEAD=3, small mode. At h=13, v=2 -> req_x=1, req_y=3, req_valid=1. At h=13, v=7 -> req_y=0, req_x=1. In frame 2, every req_valid coordinate matches bright coordinates 3 cycles later.
- Drop enable for 5 cycles at h=6, v=1 -> counters hold at (6,1) and bright=0 during the stall. After re-enable the next position is (7,1) and the frame length is extended by exactly 5 cycles.
- Assert reset for 1 cycle at h=4, v=3 -> next cycle matches the reset state (h=14, v=7, syncs inactive). The following enabled edge gives (0,0) with frame_start=1.
- Default 640x480 mode -> frame period 420000 cycles, hs period 800, hs width 96, vs width 1600 cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync, active-video flag, pixel coordinates and a
// lookahead pixel-request position leading the display by LOOKAHEAD cycles.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int LOOKAHEAD = 2,
   parameter int CW        = 11
) (
   input  logic          clk_25,
   input  logic          reset,
   input  logic          enable,
   output logic          hs,
   output logic          vs,
   output logic          bright,
   output logic [CW-1:0] h_count,
   output logic [CW-1:0] v_count,
   output logic          line_start,
   output logic          frame_start,
   output logic          req_valid,
   output logic [CW-1:0] req_x,
   output logic [CW-1:0] req_y
);

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
   localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
   localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
   localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;

   // The lookahead counter starts LOOKAHEAD positions past the reset position (last cycle
   // of the frame), carrying into the line count when it crosses the line end.
   localparam int LA_SUM   = H_TOTAL - 1 + LOOKAHEAD;
   localparam int LA_H_RST = LA_SUM % H_TOTAL;
   localparam int LA_V_RST = (V_TOTAL - 1 + LA_SUM / H_TOTAL) % V_TOTAL;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic          HS_ACT = (HS_POL != 0);
   localparam logic          VS_ACT = (VS_POL != 0);

   logic [CW-1:0] h_q, v_q, h_nxt, v_nxt;
   logic [CW-1:0] la_h_q, la_v_q, la_h_nxt, la_v_nxt;
   logic          hs_q, vs_q, bright_q, line_start_q, frame_start_q, req_valid_q;
   logic [CW-1:0] req_x_q, req_y_q;

   function automatic logic visible(logic [CW-1:0] x, logic [CW-1:0] y);
      return (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
   endfunction

   function automatic logic in_hsync(logic [CW-1:0] x);
      return (x >= CW'(H_SYNC_BEG)) && (x < CW'(H_SYNC_END));
   endfunction

   function automatic logic in_vsync(logic [CW-1:0] y);
      return (y >= CW'(V_SYNC_BEG)) && (y < CW'(V_SYNC_END));
   endfunction

   always_comb begin
      h_nxt    = (h_q == H_LAST) ? '0 : h_q + CW'(1);
      v_nxt    = v_q;
      if (h_q == H_LAST) begin
         v_nxt = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end
      la_h_nxt = (la_h_q == H_LAST) ? '0 : la_h_q + CW'(1);
      la_v_nxt = la_v_q;
      if (la_h_q == H_LAST) begin
         la_v_nxt = (la_v_q == V_LAST) ? '0 : la_v_q + CW'(1);
      end
   end

   // Outputs decode the next position so they line up with the counters they describe.
   always_ff @(posedge clk_25) begin
      if (reset) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         la_h_q        <= CW'(LA_H_RST);
         la_v_q        <= CW'(LA_V_RST);
         hs_q          <= ~HS_ACT;
         vs_q          <= ~VS_ACT;
         bright_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         req_valid_q   <= 1'b0;
         req_x_q       <= '0;
         req_y_q       <= '0;
      end else if (enable) begin
         h_q           <= h_nxt;
         v_q           <= v_nxt;
         la_h_q        <= la_h_nxt;
         la_v_q        <= la_v_nxt;
         hs_q          <= in_hsync(h_nxt) ? HS_ACT : ~HS_ACT;
         vs_q          <= in_vsync(v_nxt) ? VS_ACT : ~VS_ACT;
         bright_q      <= visible(h_nxt, v_nxt);
         line_start_q  <= (h_nxt == '0);
         frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
         req_valid_q   <= visible(la_h_nxt, la_v_nxt);
         req_x_q       <= la_h_nxt;
         req_y_q       <= la_v_nxt;
      end else begin
         bright_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         req_valid_q   <= 1'b0;
      end
   end

   assign hs          = hs_q;
   assign vs          = vs_q;
   assign bright      = bright_q;
   assign h_count     = h_q;
   assign v_count     = v_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign req_valid   = req_valid_q;
   assign req_x       = req_x_q;
   assign req_y       = req_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (small mode with lookahead 3,
// small mode with positive syncs and no lookahead, default 640x480) share one stimulus.
`timescale 1ns/1ps
module tb_vga_timing_gen;
   localparam int CW = 11;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   always #5 clk = ~clk;

   logic          a_hs, a_vs, a_br, a_ls, a_fs, a_rv;
   logic [CW-1:0] a_h, a_v, a_rx, a_ry;
   logic          b_hs, b_vs, b_br, b_ls, b_fs, b_rv;
   logic [CW-1:0] b_h, b_v, b_rx, b_ry;
   logic          c_hs, c_vs, c_br, c_ls, c_fs, c_rv;
   logic [CW-1:0] c_h, c_v, c_rx, c_ry;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(0), .VS_POL(0), .LOOKAHEAD(3), .CW(CW)
   ) dut_a (
      .clk_25(clk), .reset(reset), .enable(enable),
      .hs(a_hs), .vs(a_vs), .bright(a_br), .h_count(a_h), .v_count(a_v),
      .line_start(a_ls), .frame_start(a_fs), .req_valid(a_rv), .req_x(a_rx), .req_y(a_ry)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .LOOKAHEAD(0), .CW(CW)
   ) dut_b (
      .clk_25(clk), .reset(reset), .enable(enable),
      .hs(b_hs), .vs(b_vs), .bright(b_br), .h_count(b_h), .v_count(b_v),
      .line_start(b_ls), .frame_start(b_fs), .req_valid(b_rv), .req_x(b_rx), .req_y(b_ry)
   );

   vga_timing_gen dut_c (
      .clk_25(clk), .reset(reset), .enable(enable),
      .hs(c_hs), .vs(c_vs), .bright(c_br), .h_count(c_h), .v_count(c_v),
      .line_start(c_ls), .frame_start(c_fs), .req_valid(c_rv), .req_x(c_rx), .req_y(c_ry)
   );

   typedef struct {
      logic hs, vs, bright, ls, fs, rv, chk_req;
      int   h, v, rx, ry;
   } exp_t;

   typedef struct {
      exp_t a, b, c;
   } exp3_t;

   exp3_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    t = 0;        // enabled edges since the last reset
   bit    en_last = 1'b0;

   // Reference: the frame is a flat sequence of positions; position index is t-1.
   function automatic exp_t model(int tk, bit en, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, int vb, int la, bit hp, bit vp);
      exp_t e;
      int ht = ha + hf + hsw + hb;
      int vt = va + vf + vsw + vb;
      int f  = ht * vt;
      int p, q;
      if (tk == 0) begin
         e.h = ht - 1; e.v = vt - 1; e.hs = !hp; e.vs = !vp;
         e.bright = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.rv = 1'b0;
         e.rx = 0; e.ry = 0; e.chk_req = 1'b1;
         return e;
      end
      p = (tk - 1) % f;
      e.h = p % ht;
      e.v = p / ht;
      e.hs = (e.h >= ha + hf && e.h < ha + hf + hsw) ? hp : !hp;
      e.vs = (e.v >= va + vf && e.v < va + vf + vsw) ? vp : !vp;
      e.bright = en && e.h < ha && e.v < va;
      e.ls = en && e.h == 0;
      e.fs = en && p == 0;
      q = (p + la) % f;
      e.rx = q % ht;
      e.ry = q / ht;
      e.rv = en && e.rx < ha && e.ry < va;
      e.chk_req = e.rv;
      return e;
   endfunction

   task automatic cmp(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic check_inst(string n, exp_t e, logic hs, logic vs, logic br, logic ls,
                             logic fs, logic rv, logic [CW-1:0] h, logic [CW-1:0] v,
                             logic [CW-1:0] rx, logic [CW-1:0] ry);
      cmp({n, ".h_count"}, int'(h), e.h);
      cmp({n, ".v_count"}, int'(v), e.v);
      cmp({n, ".hs"}, int'(hs), int'(e.hs));
      cmp({n, ".vs"}, int'(vs), int'(e.vs));
      cmp({n, ".bright"}, int'(br), int'(e.bright));
      cmp({n, ".line_start"}, int'(ls), int'(e.ls));
      cmp({n, ".frame_start"}, int'(fs), int'(e.fs));
      cmp({n, ".req_valid"}, int'(rv), int'(e.rv));
      if (e.chk_req) begin
         cmp({n, ".req_x"}, int'(rx), e.rx);
         cmp({n, ".req_y"}, int'(ry), e.ry);
      end
   endtask

   task automatic step(bit r, bit en);
      exp3_t x;
      @(negedge clk);
      reset  = r;
      enable = en;
      @(posedge clk);
      if (r) t = 0;
      else if (en) t++;
      en_last = en && !r;
      x.a = model(t, en_last, 8, 2, 3, 2, 4, 1, 2, 1, 3, 1'b0, 1'b0);
      x.b = model(t, en_last, 8, 2, 3, 2, 4, 1, 2, 1, 0, 1'b1, 1'b1);
      x.c = model(t, en_last, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0);
      sb.push_back(x);
   endtask

   // Monitor: outputs are presented every cycle, sampled on the falling edge.
   initial begin
      exp3_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_inst("a", e.a, a_hs, a_vs, a_br, a_ls, a_fs, a_rv, a_h, a_v, a_rx, a_ry);
            check_inst("b", e.b, b_hs, b_vs, b_br, b_ls, b_fs, b_rv, b_h, b_v, b_rx, b_ry);
            check_inst("c", e.c, c_hs, c_vs, c_br, c_ls, c_fs, c_rv, c_h, c_v, c_rx, c_ry);
         end
      end
   end

   initial begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      // Run to (6,1) of the small mode, then stall for five cycles.
      while (t != 22) step(1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0);
      // Into frame 3 at (4,3), then a single-cycle reset that overrides enable.
      while (t != 290) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (1700) step(1'b0, 1'b1);
      repeat (3000) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0));
      end
      repeat (3) @(negedge clk);
      #1;
      cmp("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
